// File: rtl/ocm_stream_reader.sv
// rtl/ocm_stream_reader.sv - read-side DMA engine streaming on-chip memory words
//
// Purpose: accepts a (start word address, word count) command, issues
// back-to-back reads on the s2 port of the on-chip memory, absorbs the fixed
// read latency in a small credit-managed return FIFO and presents the words as
// a valid/ready stream with end-of-packet marking.
//
// Ports:
//   clk_clk, reset_reset            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_addr, cmd_len               start word address, word count 0..2^ADDR_W
//   mem_address, mem_chipselect     read address / one-cycle read strobe
//   mem_clken, mem_write            constant 1 / constant 0
//   mem_writedata, mem_byteenable   constant 0 / constant all-ones
//   mem_readdata                    read data, READ_LATENCY cycles after issue
//   out_valid/out_ready             stream handshake
//   out_data, out_last              stream word, final word of the command
//   busy, done                      command in progress, one-cycle completion pulse

module ocm_stream_reader #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [ADDR_W:0]       cmd_len,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_clken,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]       addr_q;
  logic [LEN_W-1:0]        issue_rem;
  logic [LEN_W-1:0]        beats_rem;
  logic [READ_LATENCY-1:0] tag_pipe;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic [CNT_W:0]    credit_used;

  // Constant memory-port controls: read-only, all lanes, clock always enabled.
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_writedata  = '0;
  assign mem_byteenable = '1;
  assign mem_address    = addr_q;
  assign mem_chipselect = issue;

  // A read may only issue if its returned word is guaranteed a FIFO slot:
  // every word in flight or already buffered holds one credit.
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < DEPTH_L;

  assign push      = tag_pipe[READ_LATENCY-1];
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid & (beats_rem == LEN_W'(1));
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = ~reset_reset;
        if (cmd_valid && !reset_reset) begin
          state_next = (cmd_len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        issue = (issue_rem != '0) && credit_ok;
        if (issue && issue_rem == LEN_W'(1)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && beats_rem == LEN_W'(1)) begin
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command bookkeeping: issue address/count and stream beat count.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      addr_q    <= '0;
      issue_rem <= '0;
      beats_rem <= '0;
    end else if (accept) begin
      addr_q    <= cmd_addr;
      issue_rem <= cmd_len;
      beats_rem <= cmd_len;
    end else begin
      if (issue) begin
        // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
        addr_q    <= addr_q + ADDR_W'(1);
        issue_rem <= issue_rem - LEN_W'(1);
      end
      if (pop) begin
        beats_rem <= beats_rem - LEN_W'(1);
      end
    end
  end

  // Latency tag pipe and in-flight counter. Clearing the pipe on reset is what
  // keeps reads issued before reset from landing in the FIFO afterwards.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tag_pipe  <= '0;
      in_flight <= '0;
    end else begin
      tag_pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      case ({issue, push})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Return FIFO control. Push and pop in the same cycle leave the count alone.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage has no reset; validity is tracked entirely by the pointers/count.
  // The head entry is a register, so out_data holds while the stream stalls.
  always_ff @(posedge clk_clk) begin
    if (push && !reset_reset) begin
      fifo_mem[wr_ptr] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_ocm_stream_reader.sv
// tb/tb_ocm_stream_reader.sv - self-checking bench for ocm_stream_reader
module tb_ocm_stream_reader;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic                clk = 1'b0;
  logic                reset_reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [ADDR_W:0]     cmd_len;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_clken;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_readdata = '0;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  ocm_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  function automatic logic [63:0] mem_word(input logic [13:0] a);
    return {18'h2B5A5, a, 32'h1234_5678 ^ {a, a, 4'h9}};
  endfunction

  // Memory model: one-cycle read latency on port s2.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken && !mem_write) begin
      mem_readdata <= mem_word(mem_address);
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [13:0] addr;
    logic [14:0] len;
    int          ready_mode;  // 0: always ready, 1: 1,0,0,1 repeating
    bit          spam;        // hold cmd_valid high while busy
    int          exp_first;   // cycle of first out_valid after accept, -1 none
    int          exp_done;    // cycle of done pulse after accept
    int          exp_cs;      // number of chipselect pulses
  } vec_t;

  beat_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int          cyc, first, done_cyc, cs_cnt, issued, popped, w, budget;
    logic [13:0] exp_addr, a;
    logic [63:0] hold_data;
    logic        hold_last, stalled;
    beat_t       b;

    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_before", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    out_ready = 1'b1;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.addr + 14'(i);
      b.data = mem_word(a);
      b.last = (i == int'(v.len) - 1);
      sb_q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (v.spam) begin
      cmd_addr = 14'h2AAA;
      cmd_len  = 15'd3;
    end else begin
      cmd_valid = 1'b0;
    end

    cyc = 0; first = -1; done_cyc = -1; cs_cnt = 0; issued = 0; popped = 0;
    exp_addr = v.addr; stalled = 1'b0; hold_data = '0; hold_last = 1'b0;
    budget = 4 * int'(v.len) + 40;
    while (done_cyc < 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      out_ready = (v.ready_mode == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
      if (cyc == 1) check("busy_after_accept", 64'(busy), 64'(v.len != 0));
      if (v.spam && busy) check("cmd_ready_while_busy", 64'(cmd_ready), 64'(0));
      if (mem_chipselect) begin
        check("mem_address", 64'(mem_address), 64'(exp_addr));
        exp_addr = exp_addr + 14'd1;
        cs_cnt++;
        issued++;
        check("outstanding_le_depth", 64'((issued - popped) <= DEPTH), 64'(1));
      end
      if (out_valid && first < 0) first = cyc;
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", out_data, hold_data);
        check("stall_last", 64'(out_last), 64'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %h expected no beat", out_data);
        end else begin
          b = sb_q.pop_front();
          check("beat_data", out_data, b.data);
          check("beat_last", 64'(out_last), 64'(b.last));
        end
        popped++;
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (done) begin
        done_cyc  = cyc;
        cmd_valid = 1'b0;
      end
    end
    check("first_valid_cycle", 64'(first), 64'(v.exp_first));
    check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    check("chipselect_count", 64'(cs_cnt), 64'(v.exp_cs));
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("cmd_ready_after_done", 64'(cmd_ready), 64'(1));
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   pops, n;
    logic [13:0] a;

    vecs[0] = '{14'h0010, 15'd4,     0, 1'b0, 3, 7,     4};
    vecs[1] = '{14'h3FFE, 15'd4,     0, 1'b0, 3, 7,     4};
    vecs[2] = '{14'h0200, 15'd0,     0, 1'b0, -1, 1,    0};
    vecs[3] = '{14'h0020, 15'd16,    1, 1'b1, 3, 34,    16};
    vecs[4] = '{14'h1234, 15'd1,     0, 1'b0, 3, 4,     1};
    vecs[5] = '{14'h0000, 15'd16384, 0, 1'b0, 3, 16387, 16384};

    reset_reset = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_chipselect", 64'(mem_chipselect), 64'(0));
    check("rst_mem_address", 64'(mem_address), 64'(0));
    check("const_ctrl", 64'({mem_clken, mem_write, mem_byteenable}), 64'({1'b1, 1'b0, 8'hFF}));
    check("const_wdata", mem_writedata, 64'(0));
    reset_reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // Reset one cycle after the third beat of an 8-word command.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 14'h0040;
    cmd_len   = 15'd8;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    pops = 0;
    n = 0;
    while (pops < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) begin
        a = 14'h0040 + 14'(pops);
        check("pre_reset_beat", out_data, mem_word(a));
        pops++;
      end
    end
    check("pre_reset_beats", 64'(pops), 64'(3));
    @(negedge clk);
    reset_reset = 1'b1;
    check("reset_cycle_done", 64'(done), 64'(0));
    @(negedge clk);
    reset_reset = 1'b0;
    check("post_reset_out_valid", 64'(out_valid), 64'(0));
    check("post_reset_busy", 64'(busy), 64'(0));
    check("post_reset_done", 64'(done), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_idle_valid", 64'(out_valid), 64'(0));
      check("post_reset_idle_done", 64'(done), 64'(0));
    end

    v = '{14'h0100, 15'd2, 0, 1'b0, 3, 5, 2};
    run_cmd(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
